stream_rr_arbiter: RTL and testbench
====================================

// Module: stream_rr_arbiter
//
// PURPOSE
// Shares one valid/ready output stream between N_IN upstream requesters, with round-robin fairness.
// Grants are held for a whole packet, from first beat through the beat with last=1. No packet is interleaved.
// Sits in front of a skid stage or consumer that cannot be duplicated per source.
// Output is registered; every accepted beat is tagged with the index of its source.
//
// PARAMETERS
// WIDTH   16  data bits per beat
// N_IN    4   number of requesters (>=2); SRC_W = $clog2(N_IN)
//
// PORTS
// i_clock      in   1            single clock, all logic on posedge
// i_reset      in   1            synchronous, active-high reset
// i_in_data    in   N_IN*WIDTH   requester k data at [k*WIDTH +: WIDTH]
// i_in_valid   in   N_IN         per-requester valid
// i_in_last    in   N_IN         per-requester end-of-packet flag, qualified by valid
// o_in_ready   out  N_IN         per-requester ready; at most one bit high per cycle
// o_out_data   out  WIDTH        registered output beat
// o_out_valid  out  1            registered output valid
// o_out_last   out  1            registered end-of-packet flag
// o_out_src    out  SRC_W        index of the requester that produced the current beat
// i_out_ready  in   1            downstream ready
//
// BEHAVIOUR
// - Reset: state=ST_IDLE, rr_ptr=0, grant=0, o_out_valid=0, o_out_data=0, o_out_last=0, o_out_src=0.
// - o_in_ready is forced to all-zero whenever i_reset=1.
// - Output slot free: slot_free = ~o_out_valid | i_out_ready. Input accept = valid & ready on the same edge.
// - Latency: an accepted beat appears on o_out_* the next cycle. Sustains 1 beat/clk with downstream ready held high.
// - Output hold: while o_out_valid & ~i_out_ready, o_out_data, o_out_last and o_out_src stay stable.
// - Output clear: when o_out_valid=1, i_out_ready=1 and nothing is accepted that cycle, o_out_valid goes to 0.
// - ST_IDLE:
//   - sel = first k with i_in_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N_IN.
//   - If some valid is high: o_in_ready[sel] = slot_free; all other ready bits are 0.
//   - On accept with last=1: stay in ST_IDLE, rr_ptr <= (sel+1) mod N_IN.
//   - On accept with last=0: grant <= sel, go to ST_LOCKED.
//   - No accept (nothing valid, or slot not free): no state change. Selection is recomputed every cycle.
// - ST_LOCKED:
//   - o_in_ready[grant] = slot_free; all other ready bits are 0, whatever their valid.
//   - Accept with last=1: go to ST_IDLE, rr_ptr <= (grant+1) mod N_IN.
//   - Accept with last=0: stay in ST_LOCKED. Granted valid low (bubble): stay in ST_LOCKED, no output beat.
// - Wrap-around: the pointer increment wraps N_IN-1 -> 0, including for N_IN that is not a power of 2.
// - Simultaneous events: a new beat is accepted on the same edge the held beat drains. No bubble inserted.
// - Reset mid-packet: the packet is abandoned, the in-flight output beat is dropped, all state returns to reset values.
// - Unused states of the state register decode as ST_IDLE.
//
// TESTING
// 1. All 4 valid, single-beat packets (last=1), out_ready=1 -> o_out_src sequence 0,1,2,3,0,...; one beat/clk after 1-cycle latency.
// 2. Req1 sends 3 beats A,B,C (last on C) while req0/req2 are valid -> out A,B,C all src=1, contiguous; then src=2, then src=0.
// 3. out_ready low for 5 cycles with beat 0x1234 held -> o_out_data stays 0x1234, all o_in_ready=0; resumes with no loss or duplication.
// 4. Locked on req3, req3 valid low for 2 cycles mid-packet -> no other source is granted, o_out_valid deasserts, packet completes afterwards.
// 5. Reset asserted during a 4-beat packet after beat 2 -> next cycle o_out_valid=0; after release, arbitration starts at src 0.
// 6. N_IN=3, only req2 valid with single beats -> src 2 every beat; rr_ptr wraps 2->0 and stays fair when req0 joins.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Purpose : round-robin N_IN:1 packet arbiter onto a single valid/ready stream, beats tagged with source.
// Latency : 1 cycle from input accept to registered output; sustains 1 beat/clk when downstream is ready.
// Backpr. : granted requester sees ready only while the output register is empty or draining this cycle.
//
// Ports
//   i_clock / i_reset          single clock, synchronous active-high reset
//   i_in_data/valid/last       requester k uses data[k*WIDTH +: WIDTH], valid[k], last[k]
//   o_in_ready                 per-requester ready, at most one bit high, all low during reset
//   o_out_data/valid/last/src  registered output beat and the index of the requester it came from
//   i_out_ready                downstream ready
module stream_rr_arbiter #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    localparam int SRC_W = $clog2(N_IN)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [N_IN*WIDTH-1:0] i_in_data,
    input  logic [N_IN-1:0]       i_in_valid,
    input  logic [N_IN-1:0]       i_in_last,
    output logic [N_IN-1:0]       o_in_ready,
    output logic [WIDTH-1:0]      o_out_data,
    output logic                  o_out_valid,
    output logic                  o_out_last,
    output logic [SRC_W-1:0]      o_out_src,
    input  logic                  i_out_ready
);

    // Encodings 2'b10 / 2'b11 are unreachable; every decoder below treats them as ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOCKED = 2'b01
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_ptr_nxt;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] grant_nxt;
    logic [SRC_W-1:0] sel;
    logic [SRC_W-1:0] cur_src;
    logic             locked;
    logic             any_valid;
    logic             slot_free;
    logic             accept;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;
    logic [N_IN-1:0]  in_ready;
    int               scan_idx;

    // Increment with explicit wrap so non-power-of-2 N_IN never reaches an unused index.
    function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] p);
        if (p == SRC_W'(N_IN - 1)) begin
            return '0;
        end
        return p + SRC_W'(1);
    endfunction

    assign locked    = (state == ST_LOCKED);
    // The output register can take a new beat if it is empty or its beat leaves this edge.
    assign slot_free = ~o_out_valid | i_out_ready;

    // Round-robin scan: offset i from rr_ptr, first valid requester wins.
    always_comb begin
        sel       = '0;
        any_valid = 1'b0;
        scan_idx  = 0;
        for (int i = 0; i < N_IN; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= N_IN) begin
                scan_idx = scan_idx - N_IN;
            end
            for (int k = 0; k < N_IN; k++) begin
                if (!any_valid && (k == scan_idx) && i_in_valid[k]) begin
                    any_valid = 1'b1;
                    sel       = SRC_W'(k);
                end
            end
        end
    end

    // While a packet is in progress the grant is frozen; otherwise the fresh selection is used.
    assign cur_src = locked ? grant : sel;

    always_comb begin
        in_ready = '0;
        if (!i_reset && (locked || any_valid)) begin
            for (int k = 0; k < N_IN; k++) begin
                if (cur_src == SRC_W'(k)) begin
                    in_ready[k] = slot_free;
                end
            end
        end
    end

    assign o_in_ready = in_ready;
    assign accept     = |(in_ready & i_in_valid);

    // Beat mux for the current source.
    always_comb begin
        acc_data = '0;
        acc_last = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (cur_src == SRC_W'(k)) begin
                acc_data = i_in_data[k*WIDTH +: WIDTH];
                acc_last = i_in_last[k];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant;
        case (state)
            ST_LOCKED: begin
                // A bubble on the granted requester keeps the lock; nobody else may cut in.
                if (accept && acc_last) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = ptr_inc(grant);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (acc_last) begin
                        rr_ptr_nxt = ptr_inc(sel);
                    end else begin
                        grant_nxt = sel;
                        state_nxt = ST_LOCKED;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_last  <= 1'b0;
            o_out_src   <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            grant  <= grant_nxt;
            // Loading on the same edge the held beat drains keeps the stream bubble-free.
            if (accept) begin
                o_out_valid <= 1'b1;
                o_out_data  <= acc_data;
                o_out_last  <= acc_last;
                o_out_src   <= cur_src;
            end else if (i_out_ready) begin
                o_out_valid <= 1'b0;
            end
        end
    end

    // Structural invariants.
    a_ready_onehot : assert property (@(posedge i_clock) $onehot0(o_in_ready));

    a_hold_stable : assert property (@(posedge i_clock)
        (o_out_valid && !i_out_ready && !i_reset) |=> $stable({o_out_data, o_out_last, o_out_src}));

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;
    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    logic out_rdy;

    logic [4*WIDTH-1:0] d4_data;
    logic [3:0]         d4_valid;
    logic [3:0]         d4_last;
    logic [3:0]         d4_ready;
    logic [WIDTH-1:0]   o4_data;
    logic               o4_valid;
    logic               o4_last;
    logic [1:0]         o4_src;

    logic [3*WIDTH-1:0] d3_data;
    logic [2:0]         d3_valid;
    logic [2:0]         d3_last;
    logic [2:0]         d3_ready;
    logic [WIDTH-1:0]   o3_data;
    logic               o3_valid;
    logic               o3_last;
    logic [1:0]         o3_src;

    int n_tests;
    int n_fail;

    // Per-requester beat buffers: {last, data}.
    logic [WIDTH:0] sbuf [4][64];
    int             shead [4];
    int             stail [4];
    logic [3:0]     hold;
    logic           use3;
    logic           out_rdy_ctl;

    // Expected output beats: {src, last, data}.
    logic [18:0] exp4 [$];
    logic [18:0] exp3 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_rr_arbiter #(.WIDTH(WIDTH), .N_IN(4)) dut4 (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_in_data   (d4_data),
        .i_in_valid  (d4_valid),
        .i_in_last   (d4_last),
        .o_in_ready  (d4_ready),
        .o_out_data  (o4_data),
        .o_out_valid (o4_valid),
        .o_out_last  (o4_last),
        .o_out_src   (o4_src),
        .i_out_ready (out_rdy)
    );

    stream_rr_arbiter #(.WIDTH(WIDTH), .N_IN(3)) dut3 (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_in_data   (d3_data),
        .i_in_valid  (d3_valid),
        .i_in_last   (d3_last),
        .o_in_ready  (d3_ready),
        .o_out_data  (o3_data),
        .o_out_valid (o3_valid),
        .o_out_last  (o3_last),
        .o_out_src   (o3_src),
        .i_out_ready (out_rdy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_stim(input int k, input logic last, input logic [15:0] d);
        sbuf[k][stail[k]] = {last, d};
        stail[k] = stail[k] + 1;
    endtask

    function automatic logic stim_pending();
        logic p;
        p = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (shead[k] != stail[k]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic flush_stim();
        for (int k = 0; k < 4; k++) shead[k] = stail[k];
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((exp4.size() != 0 || exp3.size() != 0 || stim_pending()) && c < 200) begin
            cycles(1);
            c++;
        end
        n_tests++;
        if (c >= 200) begin
            n_fail++;
            $display("FAIL %s drain timeout: %0d beats still expected, required 0", name,
                     exp4.size() + exp3.size());
            exp4.delete();
            exp3.delete();
            flush_stim();
        end
        cycles(2);
    endtask

    task automatic wait_pop(input string name, input int k, input int target);
        int c;
        c = 0;
        while (shead[k] < target && c < 50) begin
            cycles(1);
            c++;
        end
        n_tests++;
        if (c >= 50) begin
            n_fail++;
            $display("FAIL %s accept timeout: got %0d accepted, required %0d", name, shead[k], target);
        end
    endtask

    // Stimulus driver: presents each requester's head beat, pops it when accepted.
    initial begin : driver
        logic [3:0] fire;
        forever begin
            @(negedge clk);
            out_rdy  = out_rdy_ctl;
            d4_valid = '0;
            d4_last  = '0;
            d3_valid = '0;
            d3_last  = '0;
            if (!use3) begin
                for (int k = 0; k < 4; k++) begin
                    if (shead[k] != stail[k] && !hold[k]) begin
                        d4_valid[k] = 1'b1;
                        d4_last[k]  = sbuf[k][shead[k]][WIDTH];
                        d4_data[k*WIDTH +: WIDTH] = sbuf[k][shead[k]][WIDTH-1:0];
                    end
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (shead[k] != stail[k] && !hold[k]) begin
                        d3_valid[k] = 1'b1;
                        d3_last[k]  = sbuf[k][shead[k]][WIDTH];
                        d3_data[k*WIDTH +: WIDTH] = sbuf[k][shead[k]][WIDTH-1:0];
                    end
                end
            end
            #1;
            if (use3) fire = {1'b0, d3_valid & d3_ready};
            else      fire = d4_valid & d4_ready;
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                if (fire[k]) shead[k] = shead[k] + 1;
            end
        end
    end

    // Monitor: every beat taken by downstream is popped from its scoreboard and compared.
    initial begin : monitor
        logic [18:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (o4_valid && out_rdy) begin
                n_tests++;
                if (exp4.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat4: got src=%0d last=%0b data=%h, required no beat", o4_src, o4_last, o4_data);
                end else begin
                    e = exp4.pop_front();
                    if ({o4_src, o4_last, o4_data} !== e) begin
                        n_fail++;
                        $display("FAIL beat4: got src=%0d last=%0b data=%h, required src=%0d last=%0b data=%h",
                                 o4_src, o4_last, o4_data, e[18:17], e[16], e[15:0]);
                    end
                end
            end
            if (o3_valid && out_rdy) begin
                n_tests++;
                if (exp3.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat3: got src=%0d last=%0b data=%h, required no beat", o3_src, o3_last, o3_data);
                end else begin
                    e = exp3.pop_front();
                    if ({o3_src, o3_last, o3_data} !== e) begin
                        n_fail++;
                        $display("FAIL beat3: got src=%0d last=%0b data=%h, required src=%0d last=%0b data=%h",
                                 o3_src, o3_last, o3_data, e[18:17], e[16], e[15:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin : main
        int base;
        n_tests     = 0;
        n_fail      = 0;
        hold        = '0;
        use3        = 1'b0;
        out_rdy_ctl = 1'b1;
        out_rdy     = 1'b1;
        d4_data     = '0;
        d4_valid    = '0;
        d4_last     = '0;
        d3_data     = '0;
        d3_valid    = '0;
        d3_last     = '0;
        for (int k = 0; k < 4; k++) begin
            shead[k] = 0;
            stail[k] = 0;
        end
        rst = 1'b1;
        cycles(3);

        // Reset values
        check("rst_out_valid", 32'(o4_valid), 32'd0);
        check("rst_out_data",  32'(o4_data),  32'd0);
        check("rst_out_last",  32'(o4_last),  32'd0);
        check("rst_out_src",   32'(o4_src),   32'd0);
        check("rst_out_valid3", 32'(o3_valid), 32'd0);

        // Test 1: all four requesters, single-beat packets, two rounds -> src 0,1,2,3,0,1,2,3
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                exp4.push_back({2'(k), 1'b1, 16'h1000 + 16'(r * 16 + k)});
                push_stim(k, 1'b1, 16'h1000 + 16'(r * 16 + k));
            end
        end
        cycles(1);
        check("rst_in_ready_forced_low", 32'(d4_ready), 32'd0);
        rst = 1'b0;
        cycles(1);
        for (int i = 0; i < 8; i++) begin
            check("t1_back_to_back_valid", 32'(o4_valid), 32'd1);
            cycles(1);
        end
        check("t1_valid_clears_after_stream", 32'(o4_valid), 32'd0);
        wait_idle("t1");

        // Test 2: rr_ptr moved to 1 by a lone req0 beat; then req1 3-beat packet vs req0/req2
        exp4.push_back({2'd0, 1'b1, 16'h2000});
        push_stim(0, 1'b1, 16'h2000);
        wait_idle("t2_prep");
        exp4.push_back({2'd1, 1'b0, 16'h2101});
        exp4.push_back({2'd1, 1'b0, 16'h2102});
        exp4.push_back({2'd1, 1'b1, 16'h2103});
        exp4.push_back({2'd2, 1'b1, 16'h2200});
        exp4.push_back({2'd0, 1'b1, 16'h2300});
        push_stim(1, 1'b0, 16'h2101);
        push_stim(1, 1'b0, 16'h2102);
        push_stim(1, 1'b1, 16'h2103);
        push_stim(0, 1'b1, 16'h2300);
        push_stim(2, 1'b1, 16'h2200);
        wait_idle("t2");

        // Test 3: downstream stalls 5 cycles with 0x1234 held (rr_ptr=1 -> req2 first, then req3)
        out_rdy_ctl = 1'b0;
        exp4.push_back({2'd2, 1'b1, 16'h1234});
        exp4.push_back({2'd3, 1'b1, 16'h5678});
        push_stim(2, 1'b1, 16'h1234);
        push_stim(3, 1'b1, 16'h5678);
        begin
            int c;
            c = 0;
            while (!o4_valid && c < 10) begin
                cycles(1);
                c++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_held_data",  32'(o4_data),  32'h1234);
            check("t3_held_src",   32'(o4_src),   32'd2);
            check("t3_ready_low",  32'(d4_ready), 32'd0);
            cycles(1);
        end
        out_rdy_ctl = 1'b1;
        wait_idle("t3");

        // Test 4: locked on req3, two-cycle bubble; req0/req1 must wait (rr_ptr=0 afterwards -> 0,1)
        exp4.push_back({2'd3, 1'b0, 16'h4000});
        exp4.push_back({2'd3, 1'b0, 16'h4001});
        exp4.push_back({2'd3, 1'b1, 16'h4002});
        exp4.push_back({2'd0, 1'b1, 16'h4100});
        exp4.push_back({2'd1, 1'b1, 16'h4200});
        base = shead[3];
        push_stim(3, 1'b0, 16'h4000);
        push_stim(3, 1'b0, 16'h4001);
        push_stim(3, 1'b1, 16'h4002);
        wait_pop("t4_first_beat", 3, base + 1);
        hold[3] = 1'b1;
        push_stim(0, 1'b1, 16'h4100);
        push_stim(1, 1'b1, 16'h4200);
        cycles(1);
        check("t4_bubble_out_valid", 32'(o4_valid), 32'd0);
        check("t4_bubble_ready_a",   32'(d4_ready), 32'h8);
        cycles(1);
        check("t4_bubble_ready_b",   32'(d4_ready), 32'h8);
        hold[3] = 1'b0;
        wait_idle("t4");

        // Test 5: reset after the second beat of a 4-beat req1 packet; that beat is dropped
        exp4.push_back({2'd1, 1'b0, 16'h5000});
        base = shead[1];
        push_stim(1, 1'b0, 16'h5000);
        push_stim(1, 1'b0, 16'h5001);
        push_stim(1, 1'b0, 16'h5002);
        push_stim(1, 1'b1, 16'h5003);
        wait_pop("t5_two_beats", 1, base + 2);
        rst         = 1'b1;
        out_rdy_ctl = 1'b0;
        cycles(1);
        check("t5_rst_out_valid", 32'(o4_valid), 32'd0);
        check("t5_rst_out_data",  32'(o4_data),  32'd0);
        check("t5_rst_in_ready",  32'(d4_ready), 32'd0);
        flush_stim();
        for (int k = 0; k < 4; k++) begin
            exp4.push_back({2'(k), 1'b1, 16'h5100 + 16'(k)});
            push_stim(k, 1'b1, 16'h5100 + 16'(k));
        end
        rst         = 1'b0;
        out_rdy_ctl = 1'b1;
        wait_idle("t5");

        // Test 6: N_IN=3, only req2 -> src 2 each time; then req0 joins -> 0,2,0,2
        use3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp3.push_back({2'd2, 1'b1, 16'h6000 + 16'(i)});
            push_stim(2, 1'b1, 16'h6000 + 16'(i));
        end
        wait_idle("t6_solo");
        exp3.push_back({2'd0, 1'b1, 16'h6100});
        exp3.push_back({2'd2, 1'b1, 16'h6200});
        exp3.push_back({2'd0, 1'b1, 16'h6101});
        exp3.push_back({2'd2, 1'b1, 16'h6201});
        push_stim(0, 1'b1, 16'h6100);
        push_stim(0, 1'b1, 16'h6101);
        push_stim(2, 1'b1, 16'h6200);
        push_stim(2, 1'b1, 16'h6201);
        wait_idle("t6_shared");

        check("end_scoreboard4_empty", 32'(exp4.size()), 32'd0);
        check("end_scoreboard3_empty", 32'(exp3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
